key_debouncer: RTL

Conditions a raw, asynchronous push-button or switch input into the clean data level that drives the D input of the latch/flip-flop storage stage downstream. The block synchronises the raw input into the Clk domain and filters contact bounce with a qualification counter and FSM. It outputs the stable level plus one-cycle rise and fall strobes, so downstream logic sees exactly one transition per physical press or release.

---
 rtl/key_debouncer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/key_debouncer.sv
// Push-button / switch conditioner: two-flop synchroniser followed by a
// qualification FSM that emits a clean level plus one-cycle edge strobes.
module key_debouncer #(
   parameter int STABLE_CNT = 1000000,
   parameter int CNT_W      = 20
) (
   input  logic Clk,
   input  logic Resetn,
   input  logic KEY_in,
   output logic D_out,
   output logic rise_pulse,
   output logic fall_pulse,
   output logic busy
);

   localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CNT);

   typedef enum logic [1:0] {
      IDLE_LOW,
      WAIT_HIGH,
      IDLE_HIGH,
      WAIT_LOW
   } state_t;

   state_t           state;
   logic             s1;
   logic             s;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;

   // cnt holds the differing samples already seen; cnt_inc includes the current one
   assign cnt_inc = cnt + CNT_W'(1);

   // Synchroniser stage: only s is used downstream
   always_ff @(posedge Clk or negedge Resetn) begin
      if (!Resetn) begin
         s1 <= 1'b0;
         s  <= 1'b0;
      end else begin
         s1 <= KEY_in;
         s  <= s1;
      end
   end

   // Qualification stage
   always_ff @(posedge Clk or negedge Resetn) begin
      if (!Resetn) begin
         state      <= IDLE_LOW;
         cnt        <= '0;
         D_out      <= 1'b0;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
         busy       <= 1'b0;
      end else begin
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
         case (state)
            IDLE_LOW: begin
               if (s) begin
                  if (cnt_inc == STABLE) begin
                     state      <= IDLE_HIGH;
                     cnt        <= '0;
                     D_out      <= 1'b1;
                     rise_pulse <= 1'b1;
                     busy       <= 1'b0;
                  end else begin
                     state <= WAIT_HIGH;
                     cnt   <= cnt_inc;
                     busy  <= 1'b1;
                  end
               end else begin
                  cnt <= '0;
               end
            end
            WAIT_HIGH: begin
               if (!s) begin
                  state <= IDLE_LOW;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end else if (cnt_inc == STABLE) begin
                  state      <= IDLE_HIGH;
                  cnt        <= '0;
                  D_out      <= 1'b1;
                  rise_pulse <= 1'b1;
                  busy       <= 1'b0;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            IDLE_HIGH: begin
               if (!s) begin
                  if (cnt_inc == STABLE) begin
                     state      <= IDLE_LOW;
                     cnt        <= '0;
                     D_out      <= 1'b0;
                     fall_pulse <= 1'b1;
                     busy       <= 1'b0;
                  end else begin
                     state <= WAIT_LOW;
                     cnt   <= cnt_inc;
                     busy  <= 1'b1;
                  end
               end else begin
                  cnt <= '0;
               end
            end
            WAIT_LOW: begin
               if (s) begin
                  state <= IDLE_HIGH;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end else if (cnt_inc == STABLE) begin
                  state      <= IDLE_LOW;
                  cnt        <= '0;
                  D_out      <= 1'b0;
                  fall_pulse <= 1'b1;
                  busy       <= 1'b0;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            default: begin
               state <= IDLE_LOW;
               cnt   <= '0;
               D_out <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
